// File: rtl/psp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psp_pkg
// Description : Shared types and default parameter values for the PSP memory
//               arbiter (FSM state, last-served tag, counter sizing helper).
// Revision    : 1.0 - initial release
// ============================================================================
package psp_pkg;

    localparam int c_DEF_ADDR_W  = 32;
    localparam int c_DEF_DATA_W  = 32;
    localparam int c_DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        LAST_I = 1'b0,
        LAST_D = 1'b1
    } last_srv_t;

    // Bits needed for a counter that must be able to hold 'limit'.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/psp_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : psp_mem_arbiter
// Description : Two-port (instruction fetch / data) arbiter in front of a
//               single memory port. Round-robin on ties, registered memory
//               request, per-transaction timeout with sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module psp_mem_arbiter
    import psp_pkg::*;
#(
    parameter int ADDR_W  = c_DEF_ADDR_W,
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int TIMEOUT = c_DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset_n,
    // instruction fetch side
    input  logic                i_read,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_resp,
    // data side
    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_resp,
    // shared memory port
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp,
    // status
    output logic                timeout_err
);

    localparam int                c_CNT_W       = cnt_width(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_CNT = c_CNT_W'(TIMEOUT);

    arb_state_t            r_state;
    last_srv_t             r_last;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic [DATA_W/8-1:0]   r_mem_wmask;
    logic                  r_timeout_err;

    logic                  w_d_req;
    logic                  w_grant_d;
    logic                  w_grant_i;
    logic                  w_busy_i;
    logic                  w_busy_d;
    logic                  w_busy;
    logic                  w_timeout;
    logic                  w_done;
    logic [c_CNT_W-1:0]    w_cnt_next;

    // Tie-break favours whichever side was not served last.
    assign w_d_req    = d_read | d_write;
    assign w_grant_d  = w_d_req && (!i_read || (r_last == LAST_I));
    assign w_grant_i  = i_read && !w_grant_d;

    assign w_busy_i   = (r_state == ST_BUSY_I);
    assign w_busy_d   = (r_state == ST_BUSY_D);
    assign w_busy     = w_busy_i | w_busy_d;
    // The timeout cycle wins over a late mem_resp: the request was already dropped.
    assign w_timeout  = w_busy && (r_cnt == c_TIMEOUT_CNT);
    assign w_done     = w_busy && mem_resp && !w_timeout;
    assign w_cnt_next = r_cnt + 1'b1;

    // Completion pulses and read data are steered to the owner only; idle gives zeros.
    assign i_resp  = w_busy_i && (w_done || w_timeout);
    assign d_resp  = w_busy_d && (w_done || w_timeout);
    assign i_rdata = (w_busy_i && w_done) ? mem_rdata : '0;
    assign d_rdata = (w_busy_d && w_done) ? mem_rdata : '0;

    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_wmask   = r_mem_wmask;
    assign timeout_err = r_timeout_err;

    // Arbitration FSM: grant, hold the memory request, finish on resp or timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_last        <= LAST_I;
            r_cnt         <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_wmask   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_grant_d) begin
                        r_state     <= ST_BUSY_D;
                        r_last      <= LAST_D;
                        r_mem_read  <= d_read;
                        r_mem_write <= d_write;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_mem_wmask <= d_wmask;
                    end else if (w_grant_i) begin
                        r_state     <= ST_BUSY_I;
                        r_last      <= LAST_I;
                        r_mem_read  <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= i_addr;
                        r_mem_wdata <= '0;
                        r_mem_wmask <= '0;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    if (w_timeout) begin
                        r_state       <= ST_IDLE;
                        r_cnt         <= '0;
                        r_mem_read    <= 1'b0;
                        r_mem_write   <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else if (mem_resp) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_next;
                        // Withdraw the request as the limit is reached so the
                        // timeout cycle itself carries no memory request.
                        if (w_cnt_next == c_TIMEOUT_CNT) begin
                            r_mem_read  <= 1'b0;
                            r_mem_write <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psp_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_psp_mem_arbiter
// Description : Directed self-checking bench for psp_mem_arbiter (TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psp_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic                clk;
    logic                reset_n;
    logic                i_read;
    logic [ADDR_W-1:0]   i_addr;
    logic [DATA_W-1:0]   i_rdata;
    logic                i_resp;
    logic                d_read;
    logic                d_write;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W/8-1:0] d_wmask;
    logic [DATA_W-1:0]   d_rdata;
    logic                d_resp;
    logic                mem_read;
    logic                mem_write;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wmask;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_resp;
    logic                timeout_err;

    int n_checks;
    int n_errors;

    psp_mem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wmask    (d_wmask),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_read    = 1'b0;
        i_addr    = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_wmask   = '0;
        mem_rdata = '0;
        mem_resp  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        next();
        #1;
        check("rst_mem_read",  mem_read,    0);
        check("rst_mem_write", mem_write,   0);
        check("rst_mem_addr",  mem_addr,    0);
        check("rst_i_resp",    i_resp,      0);
        check("rst_d_resp",    d_resp,      0);
        check("rst_i_rdata",   i_rdata,     0);
        check("rst_d_rdata",   d_rdata,     0);
        check("rst_tmo_err",   timeout_err, 0);
        next();
        reset_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        clear_inputs();
        do_reset();

        // ---- single instruction fetch, resp after 3 busy cycles ----
        i_read = 1'b1;
        i_addr = 32'h100;
        #1;
        check("f_idle_i_rdata", i_rdata, 0);
        check("f_idle_d_rdata", d_rdata, 0);
        check("f_idle_mem_rd",  mem_read, 0);
        next();                               // grant edge
        #1;
        check("f_b1_mem_read",  mem_read, 1);
        check("f_b1_mem_write", mem_write, 0);
        check("f_b1_mem_addr",  mem_addr, 32'h100);
        check("f_b1_i_resp",    i_resp, 0);
        next();
        #1;
        check("f_b2_mem_read",  mem_read, 1);
        check("f_b2_i_resp",    i_resp, 0);
        next();
        mem_resp  = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        #1;
        check("f_b3_mem_read",  mem_read, 1);
        check("f_b3_i_resp",    i_resp, 1);
        check("f_b3_i_rdata",   i_rdata, 32'hDEADBEEF);
        check("f_b3_d_resp",    d_resp, 0);
        next();
        mem_resp = 1'b0;
        i_read   = 1'b0;
        #1;
        check("f_end_mem_read", mem_read, 0);
        check("f_end_i_resp",   i_resp, 0);
        check("f_end_i_rdata",  i_rdata, 0);

        // ---- simultaneous fetch + data write after reset: data first ----
        do_reset();
        i_read  = 1'b1;
        i_addr  = 32'h104;
        d_write = 1'b1;
        d_addr  = 32'h200;
        d_wdata = 32'h12345678;
        d_wmask = 4'hF;
        next();
        #1;
        check("t_d_mem_write", mem_write, 1);
        check("t_d_mem_read",  mem_read, 0);
        check("t_d_mem_addr",  mem_addr, 32'h200);
        check("t_d_mem_wdata", mem_wdata, 32'h12345678);
        check("t_d_mem_wmask", mem_wmask, 4'hF);
        next();
        mem_resp = 1'b1;
        #1;
        check("t_d_resp",      d_resp, 1);
        check("t_d_i_resp",    i_resp, 0);
        next();
        mem_resp = 1'b0;
        d_write  = 1'b0;
        #1;
        check("t_gap_mem_rd",  mem_read, 0);
        check("t_gap_mem_wr",  mem_write, 0);
        next();
        #1;
        check("t_i_mem_read",  mem_read, 1);
        check("t_i_mem_addr",  mem_addr, 32'h104);
        next();
        mem_resp  = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        #1;
        check("t_i_resp",      i_resp, 1);
        check("t_i_rdata",     i_rdata, 32'hCAFEF00D);
        check("t_i_d_resp",    d_resp, 0);
        next();
        mem_resp = 1'b0;
        i_read   = 1'b0;
        #1;
        check("t_end_mem_rd",  mem_read, 0);

        // ---- both held for 6 transactions: D,I,D,I,D,I ----
        do_reset();
        i_read = 1'b1;
        i_addr = 32'h400;
        d_read = 1'b1;
        d_addr = 32'h300;
        for (int k = 0; k < 6; k++) begin
            next();                           // grant edge
            #1;
            check("rr_mem_read", mem_read, 1);
            check("rr_mem_addr", mem_addr, (k % 2 == 0) ? 32'h300 : 32'h400);
            mem_resp  = 1'b1;
            mem_rdata = 32'hA000 + k;
            #1;
            check("rr_d_resp",   d_resp, (k % 2 == 0) ? 1 : 0);
            check("rr_i_resp",   i_resp, (k % 2 == 0) ? 0 : 1);
            next();                           // idle cycle
            mem_resp = 1'b0;
            #1;
            check("rr_idle_rd",  mem_read, 0);
        end
        i_read = 1'b0;
        d_read = 1'b0;

        // ---- data read that never gets mem_resp: timeout after 8 busy cycles ----
        do_reset();
        d_read    = 1'b1;
        d_addr    = 32'h500;
        mem_rdata = 32'hFFFFFFFF;
        next();                               // grant edge
        for (int b = 1; b <= 8; b++) begin
            if (b > 1) next();
            #1;
            check("to_busy_mem_rd", mem_read, 1);
            check("to_busy_d_resp", d_resp, 0);
        end
        next();
        #1;
        check("to_d_resp",     d_resp, 1);
        check("to_d_rdata",    d_rdata, 0);
        check("to_mem_read",   mem_read, 0);
        check("to_i_resp",     i_resp, 0);
        next();
        d_read = 1'b0;
        #1;
        check("to_err_set",    timeout_err, 1);
        check("to_after_resp", d_resp, 0);
        check("to_after_rd",   mem_read, 0);
        next();
        #1;
        check("to_err_sticky", timeout_err, 1);

        // ---- stray mem_resp while idle ----
        mem_resp  = 1'b1;
        mem_rdata = 32'h55AA55AA;
        #1;
        check("stray_i_resp",  i_resp, 0);
        check("stray_d_resp",  d_resp, 0);
        check("stray_i_rdata", i_rdata, 0);
        check("stray_d_rdata", d_rdata, 0);
        next();
        mem_resp = 1'b0;
        #1;
        check("stray_mem_rd",  mem_read, 0);

        // ---- reset mid-transaction in BUSY_I ----
        do_reset();
        i_read = 1'b1;
        i_addr = 32'h600;
        next();
        #1;
        check("ra_busy_rd",    mem_read, 1);
        mem_resp  = 1'b1;
        mem_rdata = 32'h77777777;
        reset_n   = 1'b0;
        #1;
        check("ra_mem_read",   mem_read, 0);
        check("ra_mem_addr",   mem_addr, 0);
        check("ra_i_resp",     i_resp, 0);
        check("ra_i_rdata",    i_rdata, 0);
        next();
        reset_n  = 1'b1;
        mem_resp = 1'b0;
        i_read   = 1'b0;
        next();
        #1;
        check("ra_idle_rd",    mem_read, 0);
        check("ra_idle_resp",  i_resp, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
